// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared bus widths, field offsets, FSM state type and the
// writeback bus packing helper for the memory pipeline stage.
package mem_stage_pkg;

  localparam int unsigned STAGE_2_MEM_BUS_WIDTH  = 88;
  localparam int unsigned STAGE_MEM_WB_BUS_WIDTH = 42;

  // decode_stage_2 -> mem bus field offsets (single bits / LSB of fields)
  localparam int unsigned M_RES_FROM_MEM = 87;
  localparam int unsigned M_RES_FROM_CSR = 86;
  localparam int unsigned M_GR_WE        = 85;
  localparam int unsigned M_RD_LSB       = 80;
  localparam int unsigned M_SRC1_LSB     = 48;
  localparam int unsigned M_SRC2_LSB     = 16;
  localparam int unsigned M_CSR_LSB      = 4;
  localparam int unsigned M_FLAGS_LSB    = 0;   // {jmp, excp, xret, break}

  // mem -> writeback bus field offsets
  localparam int unsigned W_GR_WE        = 41;
  localparam int unsigned W_RD_LSB       = 36;
  localparam int unsigned W_DATA_LSB     = 4;
  localparam int unsigned W_FLAGS_LSB    = 0;

  // excp_flush position inside the 4-bit flag group
  localparam logic [3:0] FLAG_EXCP_MASK = 4'b0100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } mem_state_e;

  function automatic logic [STAGE_MEM_WB_BUS_WIDTH-1:0] pack_wb(
    input logic        we,
    input logic [4:0]  rd,
    input logic [31:0] wdata,
    input logic [3:0]  flags
  );
    return {we, rd, wdata, flags};
  endfunction

endpackage

// File: rtl/mem_stage.sv
// mem_stage: memory pipeline stage. Completes word loads through a
// req/gnt/rvalid data port (with timeout), CSR reads, and address/link adds,
// emitting one registered writeback bus pulse per instruction.
// Ports:
//   clk_i, rst_ni                 clock, async active-low reset
//   decode_stage_2_valid_i/_bus_i upstream bus (88 bits)
//   mem_ready_o                   stage can accept (FSM idle)
//   dmem_req_o/_addr_o            load request and held address
//   dmem_gnt_i/_rvalid_i/_rdata_i/_err_i  data memory handshake/response
//   csr_addr_o/csr_rdata_i        combinational CSR read port
//   mem_wb_bus_o/valid_o          registered writeback bus and valid pulse
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              decode_stage_2_valid_i,
  input  logic [STAGE_2_MEM_BUS_WIDTH-1:0]  decode_stage_2_mem_bus_i,
  output logic                              mem_ready_o,
  output logic                              dmem_req_o,
  output logic [31:0]                       dmem_addr_o,
  input  logic                              dmem_gnt_i,
  input  logic                              dmem_rvalid_i,
  input  logic [31:0]                       dmem_rdata_i,
  input  logic                              dmem_err_i,
  output logic [11:0]                       csr_addr_o,
  input  logic [31:0]                       csr_rdata_i,
  output logic [STAGE_MEM_WB_BUS_WIDTH-1:0] mem_wb_bus_o,
  output logic                              valid_o
);

  // Abort fires on the WAIT edge that would bring the count to TIMEOUT_CYCLES.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  mem_state_e r_state, w_next_state;

  logic        w_res_from_mem, w_res_from_csr, w_gr_we;
  logic [4:0]  w_rd;
  logic [31:0] w_src1, w_src2, w_addr, w_wdata;
  logic [3:0]  w_flags;
  logic        w_accept, w_misalign, w_load_go, w_misload, w_we_ok;
  logic        w_wait_done, w_timeout;

  logic [31:0] r_addr;
  logic        r_ld_we;
  logic [4:0]  r_ld_rd;
  logic [3:0]  r_ld_flags;
  logic [7:0]  r_cnt;
  logic [STAGE_MEM_WB_BUS_WIDTH-1:0] r_wb;
  logic        r_valid;

  assign w_res_from_mem = decode_stage_2_mem_bus_i[M_RES_FROM_MEM];
  assign w_res_from_csr = decode_stage_2_mem_bus_i[M_RES_FROM_CSR];
  assign w_gr_we        = decode_stage_2_mem_bus_i[M_GR_WE];
  assign w_rd           = decode_stage_2_mem_bus_i[M_RD_LSB +: 5];
  assign w_src1         = decode_stage_2_mem_bus_i[M_SRC1_LSB +: 32];
  assign w_src2         = decode_stage_2_mem_bus_i[M_SRC2_LSB +: 32];
  assign csr_addr_o     = decode_stage_2_mem_bus_i[M_CSR_LSB +: 12];
  assign w_flags        = decode_stage_2_mem_bus_i[M_FLAGS_LSB +: 4];

  assign w_addr      = w_src1 + w_src2;
  assign w_accept    = decode_stage_2_valid_i && (r_state == ST_IDLE);
  assign w_misalign  = (w_addr[1:0] != 2'b00);
  assign w_load_go   = w_accept && w_res_from_mem && !w_misalign;
  assign w_misload   = w_res_from_mem && w_misalign;
  assign w_we_ok     = w_gr_we && (w_rd != '0);
  // Load wins over CSR; a misaligned load falls back to the address result.
  assign w_wdata     = (w_res_from_csr && !w_res_from_mem) ? csr_rdata_i : w_addr;
  assign w_wait_done = (r_state == ST_WAIT) && dmem_rvalid_i;
  assign w_timeout   = (r_state == ST_WAIT) && !dmem_rvalid_i && (r_cnt == TIMEOUT_LAST);

  assign mem_ready_o  = (r_state == ST_IDLE);
  assign dmem_req_o   = (r_state == ST_REQ);
  assign dmem_addr_o  = r_addr;
  assign mem_wb_bus_o = r_wb;
  assign valid_o      = r_valid;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= ST_IDLE;
    else         r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (w_load_go)                 w_next_state = ST_REQ;
      ST_REQ:  if (dmem_gnt_i)                w_next_state = ST_WAIT;
      ST_WAIT: if (w_wait_done || w_timeout)  w_next_state = ST_IDLE;
      default:                                w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_addr     <= '0;
      r_ld_we    <= 1'b0;
      r_ld_rd    <= '0;
      r_ld_flags <= '0;
      r_cnt      <= '0;
      r_wb       <= '0;
      r_valid    <= 1'b0;
    end else begin
      r_valid <= 1'b0;

      if (w_accept && !w_load_go) begin
        r_valid <= 1'b1;
        r_wb    <= pack_wb(w_we_ok && !w_misload, w_rd, w_wdata,
                           w_misload ? (w_flags | FLAG_EXCP_MASK) : w_flags);
      end

      if (w_load_go) begin
        r_addr     <= w_addr;
        r_ld_we    <= w_we_ok;
        r_ld_rd    <= w_rd;
        r_ld_flags <= w_flags;
      end

      if ((r_state == ST_REQ) && dmem_gnt_i) r_cnt <= '0;
      else if ((r_state == ST_WAIT) && !dmem_rvalid_i) r_cnt <= r_cnt + 8'd1;

      if (w_wait_done) begin
        r_valid <= 1'b1;
        r_wb    <= pack_wb(r_ld_we && !dmem_err_i, r_ld_rd,
                           dmem_err_i ? '0 : dmem_rdata_i,
                           dmem_err_i ? (r_ld_flags | FLAG_EXCP_MASK) : r_ld_flags);
      end

      if (w_timeout) begin
        r_valid <= 1'b1;
        r_wb    <= pack_wb(1'b0, r_ld_rd, '0, r_ld_flags | FLAG_EXCP_MASK);
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        decode_stage_2_valid_i;
  logic [87:0] decode_stage_2_mem_bus_i;
  logic        mem_ready_o;
  logic        dmem_req_o;
  logic [31:0] dmem_addr_o;
  logic        dmem_gnt_i;
  logic        dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;
  logic        dmem_err_i;
  logic [11:0] csr_addr_o;
  logic [31:0] csr_rdata_i;
  logic [41:0] mem_wb_bus_o;
  logic        valid_o;

  int unsigned total = 0;
  int unsigned bad   = 0;

  mem_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i                    (clk_i),
    .rst_ni                   (rst_ni),
    .decode_stage_2_valid_i   (decode_stage_2_valid_i),
    .decode_stage_2_mem_bus_i (decode_stage_2_mem_bus_i),
    .mem_ready_o              (mem_ready_o),
    .dmem_req_o               (dmem_req_o),
    .dmem_addr_o              (dmem_addr_o),
    .dmem_gnt_i               (dmem_gnt_i),
    .dmem_rvalid_i            (dmem_rvalid_i),
    .dmem_rdata_i             (dmem_rdata_i),
    .dmem_err_i               (dmem_err_i),
    .csr_addr_o               (csr_addr_o),
    .csr_rdata_i              (csr_rdata_i),
    .mem_wb_bus_o             (mem_wb_bus_o),
    .valid_o                  (valid_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [87:0] mk_bus(
    input logic mem, input logic csr, input logic we, input logic [4:0] rd,
    input logic [31:0] s1, input logic [31:0] s2, input logic [11:0] ca,
    input logic [3:0] flags
  );
    return {mem, csr, we, rd, s1, s2, ca, flags};
  endfunction

  function automatic logic [41:0] mk_wb(
    input logic we, input logic [4:0] rd, input logic [31:0] d, input logic [3:0] flags
  );
    return {we, rd, d, flags};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_ni = 1'b0;
    decode_stage_2_valid_i = 1'b0;
    decode_stage_2_mem_bus_i = '0;
    dmem_gnt_i = 1'b0;
    dmem_rvalid_i = 1'b0;
    dmem_rdata_i = '0;
    dmem_err_i = 1'b0;
    csr_rdata_i = '0;
    #2;
    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_wb", 64'(mem_wb_bus_o), 64'd0);
    chk("rst_req", 64'(dmem_req_o), 64'd0);
    chk("rst_addr", 64'(dmem_addr_o), 64'd0);
    chk("rst_ready", 64'(mem_ready_o), 64'd1);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Non-load add
    decode_stage_2_valid_i = 1'b1;
    decode_stage_2_mem_bus_i = mk_bus(0, 0, 1, 5'd5, 32'h1000, 32'd4, 12'h0, 4'b0000);
    step();
    chk("nl_valid", 64'(valid_o), 64'd1);
    chk("nl_wb", 64'(mem_wb_bus_o), 64'(mk_wb(1, 5'd5, 32'h1004, 4'b0000)));

    // rd=0 non-load back-to-back
    decode_stage_2_mem_bus_i = mk_bus(0, 0, 1, 5'd0, 32'h10, 32'h20, 12'h0, 4'b0000);
    step();
    chk("rd0_valid", 64'(valid_o), 64'd1);
    chk("rd0_wb", 64'(mem_wb_bus_o), 64'(mk_wb(0, 5'd0, 32'h30, 4'b0000)));

    // CSR read with jmp/xret pass-through, back-to-back
    decode_stage_2_mem_bus_i = mk_bus(0, 1, 1, 5'd7, 32'h4, 32'h8, 12'h300, 4'b1010);
    csr_rdata_i = 32'h1800;
    #1;
    chk("csr_addr", 64'(csr_addr_o), 64'h300);
    chk("csr_ready", 64'(mem_ready_o), 64'd1);
    step();
    chk("csr_valid", 64'(valid_o), 64'd1);
    chk("csr_wb", 64'(mem_wb_bus_o), 64'(mk_wb(1, 5'd7, 32'h1800, 4'b1010)));
    decode_stage_2_valid_i = 1'b0;
    step();
    chk("idle_valid", 64'(valid_o), 64'd0);

    // Misaligned load
    decode_stage_2_valid_i = 1'b1;
    decode_stage_2_mem_bus_i = mk_bus(1, 0, 1, 5'd3, 32'h8000_0000, 32'd2, 12'h0, 4'b0000);
    step();
    decode_stage_2_valid_i = 1'b0;
    chk("mis_req", 64'(dmem_req_o), 64'd0);
    chk("mis_valid", 64'(valid_o), 64'd1);
    chk("mis_wb", 64'(mem_wb_bus_o), 64'(mk_wb(0, 5'd3, 32'h8000_0002, 4'b0100)));
    chk("mis_ready", 64'(mem_ready_o), 64'd1);

    // Aligned load, gnt after 2 cycles, rvalid one cycle later
    decode_stage_2_valid_i = 1'b1;
    decode_stage_2_mem_bus_i = mk_bus(1, 0, 1, 5'd9, 32'h8000_0000, 32'h10, 12'h0, 4'b0000);
    step();
    decode_stage_2_valid_i = 1'b0;
    chk("ld_req1", 64'(dmem_req_o), 64'd1);
    chk("ld_addr", 64'(dmem_addr_o), 64'h8000_0010);
    chk("ld_ready1", 64'(mem_ready_o), 64'd0);
    chk("ld_valid1", 64'(valid_o), 64'd0);
    step();
    chk("ld_req2", 64'(dmem_req_o), 64'd1);
    chk("ld_ready2", 64'(mem_ready_o), 64'd0);
    chk("ld_valid2", 64'(valid_o), 64'd0);
    dmem_gnt_i = 1'b1;
    step();
    dmem_gnt_i = 1'b0;
    chk("ld_req3", 64'(dmem_req_o), 64'd0);
    chk("ld_ready3", 64'(mem_ready_o), 64'd0);
    chk("ld_valid3", 64'(valid_o), 64'd0);
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i = 32'hDEAD_BEEF;
    step();
    dmem_rvalid_i = 1'b0;
    chk("ld_valid", 64'(valid_o), 64'd1);
    chk("ld_wb", 64'(mem_wb_bus_o), 64'(mk_wb(1, 5'd9, 32'hDEAD_BEEF, 4'b0000)));
    chk("ld_ready_done", 64'(mem_ready_o), 64'd1);
    step();
    chk("ld_single_pulse", 64'(valid_o), 64'd0);

    // Load with error response
    decode_stage_2_valid_i = 1'b1;
    decode_stage_2_mem_bus_i = mk_bus(1, 0, 1, 5'd4, 32'h100, 32'h0, 12'h0, 4'b0000);
    step();
    decode_stage_2_valid_i = 1'b0;
    dmem_gnt_i = 1'b1;
    step();
    dmem_gnt_i = 1'b0;
    dmem_rvalid_i = 1'b1;
    dmem_err_i = 1'b1;
    dmem_rdata_i = 32'h55;
    step();
    dmem_rvalid_i = 1'b0;
    dmem_err_i = 1'b0;
    chk("err_valid", 64'(valid_o), 64'd1);
    chk("err_we", 64'(mem_wb_bus_o[41]), 64'd0);
    chk("err_rd", 64'(mem_wb_bus_o[40:36]), 64'd4);
    chk("err_excp", 64'(mem_wb_bus_o[2]), 64'd1);

    // Timeout with TIMEOUT_CYCLES=4
    decode_stage_2_valid_i = 1'b1;
    decode_stage_2_mem_bus_i = mk_bus(1, 0, 1, 5'd6, 32'h200, 32'h0, 12'h0, 4'b0000);
    step();
    decode_stage_2_valid_i = 1'b0;
    dmem_gnt_i = 1'b1;
    step();
    dmem_gnt_i = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step();
      chk($sformatf("to_wait%0d_valid", i), 64'(valid_o), 64'd0);
      chk($sformatf("to_wait%0d_ready", i), 64'(mem_ready_o), 64'd0);
    end
    step();
    chk("to_valid", 64'(valid_o), 64'd1);
    chk("to_wb", 64'(mem_wb_bus_o), 64'(mk_wb(0, 5'd6, 32'h0, 4'b0100)));
    chk("to_ready", 64'(mem_ready_o), 64'd1);

    // Reset during WAIT
    decode_stage_2_valid_i = 1'b1;
    decode_stage_2_mem_bus_i = mk_bus(1, 0, 1, 5'd2, 32'h300, 32'h0, 12'h0, 4'b0000);
    step();
    decode_stage_2_valid_i = 1'b0;
    dmem_gnt_i = 1'b1;
    step();
    dmem_gnt_i = 1'b0;
    #2;
    rst_ni = 1'b0;
    #1;
    chk("mrst_req", 64'(dmem_req_o), 64'd0);
    chk("mrst_valid", 64'(valid_o), 64'd0);
    chk("mrst_addr", 64'(dmem_addr_o), 64'd0);
    chk("mrst_ready", 64'(mem_ready_o), 64'd1);
    @(negedge clk_i);
    rst_ni = 1'b1;
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i = 32'h1234;
    step();
    dmem_rvalid_i = 1'b0;
    chk("stray_valid", 64'(valid_o), 64'd0);

    // Next non-load completes normally; carry out of the add is dropped
    decode_stage_2_valid_i = 1'b1;
    decode_stage_2_mem_bus_i = mk_bus(0, 0, 1, 5'd1, 32'hFFFF_FFFF, 32'd2, 12'h0, 4'b0001);
    step();
    decode_stage_2_valid_i = 1'b0;
    chk("post_valid", 64'(valid_o), 64'd1);
    chk("post_wb", 64'(mem_wb_bus_o), 64'(mk_wb(1, 5'd1, 32'h1, 4'b0001)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Consumes the `decode_stage_2` → memory pipeline bus and completes each instruction's data-side work:
- word loads through a request/grant/response data-memory port, with a timeout;
- CSR reads;
- address/link add for all other instructions.

It emits one registered writeback bus per instruction. It applies backpressure upstream via `mem_ready_o` while a load is outstanding.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 255: max cycles in WAIT before abort; range 1–255.

Ports:
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset; one clock, reset asynchronous and active-low.
- `decode_stage_2_valid_i` in 1: bus valid.
- `decode_stage_2_mem_bus_i` in `` `STAGE_2_MEM_BUS_WIDTH `` (88): fields MSB→LSB:
  - `res_from_mem`, `res_from_csr`, `gr_we`
  - `rd[4:0]`, `src1[31:0]`, `src2[31:0]`, `csr_addr[11:0]`
  - `jmp_flag`, `excp_flush`, `xret_flush`, `break_signal`
- `mem_ready_o` out 1: stage can accept this cycle.
- `dmem_req_o` out 1: load request.
- `dmem_addr_o` out 32: load address, held while `dmem_req_o`.
- `dmem_gnt_i` in 1: request accepted.
- `dmem_rvalid_i` in 1: response valid.
- `dmem_rdata_i` in 32: response data.
- `dmem_err_i` in 1: response error, qualified by `dmem_rvalid_i`.
- `csr_addr_o` out 12: CSR read address (combinational from input bus).
- `csr_rdata_i` in 32: CSR read data, same-cycle.
- `mem_wb_bus_o` out `` `STAGE_MEM_WB_BUS_WIDTH `` (42): `{gr_we, rd[4:0], wdata[31:0], jmp_flag, excp_flush, xret_flush, break_signal}`.
- `valid_o` out 1: `mem_wb_bus_o` valid, one-cycle pulse per instruction.

## Operation
- Accept = `decode_stage_2_valid_i && mem_ready_o`. `mem_ready_o` = (state==IDLE). Upstream holds its bus while not ready.
- `addr` = `src1 + src2`, mod 2^32, carry dropped.
- Result selection at accept:
  - CSR if `res_from_csr`: `wdata` = `csr_rdata_i`.
  - Load if `res_from_mem`: `res_from_mem` has priority over `res_from_csr`.
  - Otherwise: `wdata` = `addr`.
- Misaligned load (`addr[1:0]`≠0): no request issued. Completes as non-load with `excp_flush`=1, `gr_we`=0, `wdata`=`addr`.
- `gr_we` output forced 0 when `rd`==0 or any exception is raised here.
- `jmp_flag`, `xret_flush`, `break_signal` pass through unchanged. Input `excp_flush` is ORed with local exceptions.
- FSM states:
  - **IDLE**:
    - accept non-load/misaligned → output registered, stay IDLE;
    - accept aligned load → latch bus, go REQ.
  - **REQ**: `dmem_req_o`=1, `dmem_addr_o`=`addr`. On `dmem_gnt_i` → WAIT, timeout counter cleared.
  - **WAIT**:
    - `dmem_rvalid_i` → register result: `wdata`=`dmem_rdata_i`, or `excp_flush`=1/`gr_we`=0 if `dmem_err_i`; go IDLE.
    - Counter reaches `TIMEOUT_CYCLES` with no `rvalid` → `excp_flush`=1, `gr_we`=0, `wdata`=0; go IDLE.
- `dmem_rvalid_i` in IDLE or REQ is ignored. A response never arrives in the same cycle as its grant.

## Timing
- Reset (async assert, sync-safe deassert) values:
  - state=IDLE, `valid_o`=0, `mem_wb_bus_o`=0, `dmem_req_o`=0, `dmem_addr_o`=0, counter=0.
- Non-load: accepted at edge N → `valid_o`=1 for the cycle after edge N.
- Load:
  - accept at edge N → `dmem_req_o` high after N;
  - `gnt` sampled at edge N+k → WAIT;
  - `rvalid` sampled at edge M → `valid_o` high after M.
  - Minimum latency: accept→`valid_o` = 3 cycles.
- `mem_ready_o` low from the cycle after a load accept until the cycle after completion. Back-to-back non-loads sustain 1/cycle.
- Timeout: counter increments each WAIT cycle without `rvalid`. Abort at the edge where count==`TIMEOUT_CYCLES`.
- Reset mid-load: `dmem_req_o` drops immediately. A late `rvalid` after reset is ignored.

## Structure
- `riscv_param.v` gains:
  - `` `STAGE_MEM_WB_BUS_WIDTH `` (42);
  - field-offset macros for both buses;
  - FSM state encoding (IDLE=2'd0, REQ=2'd1, WAIT=2'd2).
- Single module, no sub-module. Adder, FSM and 8-bit counter are inline.

## Test plan
- Non-load: `src1`=0x1000, `src2`=4, `rd`=5, `gr_we`=1 → next cycle `valid_o`=1, `wdata`=0x1004, `gr_we`=1, `rd`=5.
- Load: `addr`=0x8000_0010, `gnt` after 2 cycles, `rvalid` 1 cycle later with 0xDEADBEEF → `wdata`=0xDEADBEEF, `mem_ready_o` low throughout, one `valid_o` pulse.
- Misaligned load to 0x8000_0002 → no `dmem_req_o`, next cycle `excp_flush`=1, `gr_we`=0. Also `rd`=0 non-load → `gr_we`=0.
- `dmem_err_i` with `rvalid` → `excp_flush`=1, `gr_we`=0. Separately, `TIMEOUT_CYCLES`=4 with no `rvalid` → abort after exactly 4 WAIT cycles.
- CSR read `csr_addr`=0x300, `csr_rdata_i`=0x1800 → `csr_addr_o`=0x300, `wdata`=0x1800. `xret_flush`/`jmp_flag` pass through.
- `rst_ni` low during WAIT → `dmem_req_o`/`valid_o` 0 immediately. Subsequent stray `rvalid` → no `valid_o`. Next non-load completes normally.
